// File: rtl/mem_stage_unit_pkg.sv
// mem_stage_unit_pkg: shared encodings and helpers for the memory stage
package mem_stage_unit_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] read_data;
    logic        misalign;
    logic        bus_err;
  } wb_t;
  // size lives in funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_unit_load_align_extend.sv
// load_align_extend: pick the addressed byte/half of a read word and extend it
module load_align_extend
  import mem_stage_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  // signed variants replicate the top bit, unsigned ones pad with zeros
  always_comb
    data_o = funct3_i == F3_B  ? {{24{byte_v[7]}}, byte_v} :
             funct3_i == F3_BU ? {24'b0, byte_v} :
             funct3_i == F3_H  ? {{16{half_v[15]}}, half_v} :
             funct3_i == F3_HU ? {16'b0, half_v} : rdata_i;
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory stage with req/ready data access, stall control and MEM/WB register
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ReadDataW,
  output logic        MisalignW,
  output logic        BusErrW
);
  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  wb_t         w_q, w_d;
  logic        is_load, access, mis, idle, tmo_hit, complete, timeout, waiting, misal;
  logic [31:0] load_data;
  assign is_load  = ResultSrcM == RES_MEM;
  assign access   = MemWriteM | is_load;
  assign mis      = misaligned(Funct3M, ALUResultM[1:0]);
  assign idle     = state_q == S_IDLE;
  assign tmo_hit  = !idle && cnt_q == 8'(TIMEOUT);
  // rst gating drops the request in the very cycle reset is sampled
  assign mem_req  = rst & (!idle | (access & !mis));
  assign complete = mem_req & mem_ready;
  assign timeout  = mem_req & !mem_ready & tmo_hit;
  assign waiting  = mem_req & !mem_ready & !tmo_hit;
  assign misal    = rst & idle & access & mis;
  assign StallM   = waiting;
  assign mem_we   = MemWriteM;
  assign mem_addr = {ALUResultM[31:2], 2'b00};
  assign mem_be   = byte_en(Funct3M, ALUResultM[1:0]);
  assign mem_wdata = Funct3M[1:0] == 2'b00 ? {4{WriteDataM[7:0]}} :
                     Funct3M[1:0] == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  load_align_extend u_lae (
    .rdata_i (mem_rdata),
    .addr_i  (ALUResultM[1:0]),
    .funct3_i(Funct3M),
    .data_o  (load_data)
  );
  // next state: bubbles while waiting, squash writes on misalign or timeout
  always_comb begin
    state_d = waiting ? S_WAIT : S_IDLE;
    cnt_d   = waiting ? cnt_q + 8'd1 : 8'd0;
    w_d = '{reg_write:  RegWriteM & !(waiting | timeout | misal),
            result_src: ResultSrcM,
            alu_result: ALUResultM,
            rd:         RdM,
            pc_plus4:   PCPlus4M,
            read_data:  (complete & is_load) ? load_data : 32'd0,
            misalign:   misal,
            bus_err:    timeout};
  end
  // state, wait counter and MEM/WB register
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  assign RegWriteW  = w_q.reg_write;
  assign ResultSrcW = w_q.result_src;
  assign ALUResultW = w_q.alu_result;
  assign RdW        = w_q.rd;
  assign PCPlus4W   = w_q.pc_plus4;
  assign ReadDataW  = w_q.read_data;
  assign MisalignW  = w_q.misalign;
  assign BusErrW    = w_q.bus_err;
endmodule
